// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch front end.
//   state_t     : fetch FSM states
//   INSTR_BYTES : PC increment per instruction
//   align_pc()  : clears the byte-offset bits [1:0] of an address
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // may issue a request for the current PC
    S_WAIT = 2'd1,  // request accepted, waiting for its response
    S_DROP = 2'd2   // in-flight response belongs to a flushed path
  } state_t;

  localparam int INSTR_BYTES = 4;

  // Wide enough for any practical PC; callers cast to their own width.
  localparam int PC_MAX_W = 64;

  function automatic logic [PC_MAX_W-1:0] align_pc(input logic [PC_MAX_W-1:0] pc);
    return {pc[PC_MAX_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg_en.sv
// pc_reg_en: width-parameterised register with load enable and async
// active-low reset to RST_VAL.
//   i_clk   : clock
//   i_rst_n : async active-low reset
//   i_en    : load i_d on the rising edge
//   i_d     : load value
//   o_q     : registered value
module pc_reg_en #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_q <= RST_VAL;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_pc.sv
// fetch_pc: program counter and instruction-fetch front end.
// Issues one imem request at a time for the current PC, captures the
// response into a single-entry slot handed to decode with valid/ready,
// and flushes the slot / in-flight fetch on a redirect.
//   i_clk, i_reset_n          : clock, async active-low reset
//   i_redirect_valid/_pc      : branch/jump redirect (target word-aligned here)
//   o_imem_req_valid/_addr    : fetch request (address = current PC)
//   i_imem_req_ready          : memory accepts request
//   i_imem_rsp_valid/_data    : fetch response
//   o_out_valid/_pc/_instr    : output slot to decode
//   i_out_ready               : decode consumes slot
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            IW       = 32
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_redirect_valid,
  input  logic [AW-1:0] i_redirect_pc,
  output logic          o_imem_req_valid,
  output logic [AW-1:0] o_imem_req_addr,
  input  logic          i_imem_req_ready,
  input  logic          i_imem_rsp_valid,
  input  logic [IW-1:0] i_imem_rsp_data,
  output logic          o_out_valid,
  output logic [AW-1:0] o_out_pc,
  output logic [IW-1:0] o_out_instr,
  input  logic          i_out_ready
);

  state_t           r_state, w_state_nxt;
  logic             r_out_valid;
  logic [AW-1:0]    w_pc;
  logic [AW-1:0]    w_pc_nxt;
  logic [AW-1:0]    w_redir_pc;
  logic             w_pc_en;
  logic             w_req_valid;
  logic             w_capture;
  logic [AW+IW-1:0] w_slot;

  assign w_redir_pc = AW'(align_pc(PC_MAX_W'(i_redirect_pc)));

  // Next state and request/capture strobes. A request is only offered when
  // the slot is empty or draining this cycle, so a response never finds the
  // slot occupied.
  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      S_REQ: begin
        // Gated by reset so nothing is presented while reset is held.
        w_req_valid = i_reset_n & ~i_redirect_valid & (~r_out_valid | i_out_ready);
        if (w_req_valid && i_imem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_capture = i_imem_rsp_valid & ~i_redirect_valid;
        if (i_imem_rsp_valid)      w_state_nxt = S_REQ;
        else if (i_redirect_valid) w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (i_imem_rsp_valid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_REQ;
    else            r_state <= w_state_nxt;
  end

  // PC only moves on redirect or on a delivered instruction; redirect wins.
  assign w_pc_en  = i_redirect_valid | w_capture;
  assign w_pc_nxt = i_redirect_valid ? w_redir_pc : w_pc + AW'(INSTR_BYTES);

  pc_reg_en #(.W(AW), .RST_VAL(RESET_PC)) u_pc (
    .i_clk   (i_clk),
    .i_rst_n (i_reset_n),
    .i_en    (w_pc_en),
    .i_d     (w_pc_nxt),
    .o_q     (w_pc)
  );

  // Slot payload holds its value after drain or flush; only valid clears.
  pc_reg_en #(.W(AW+IW), .RST_VAL('0)) u_slot (
    .i_clk   (i_clk),
    .i_rst_n (i_reset_n),
    .i_en    (w_capture),
    .i_d     ({w_pc, i_imem_rsp_data}),
    .o_q     (w_slot)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                    r_out_valid <= 1'b0;
    else if (i_redirect_valid)         r_out_valid <= 1'b0;
    else if (w_capture)                r_out_valid <= 1'b1;
    else if (r_out_valid & i_out_ready) r_out_valid <= 1'b0;
  end

  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = w_pc;
  assign o_out_valid      = r_out_valid;
  assign o_out_pc         = w_slot[AW+IW-1:IW];
  assign o_out_instr      = w_slot[IW-1:0];

endmodule

// File: tb/tb_fetch_pc.sv
module tb_fetch_pc;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // main DUT (RESET_PC = 0)
  logic        rst_n, redir, rdy, rsp, ordy;
  logic [31:0] rpc, rdat;
  logic        req_v, ov;
  logic [31:0] req_a, op, oi;

  fetch_pc #(.AW(32), .RESET_PC(32'h0), .IW(32)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_redirect_valid(redir), .i_redirect_pc(rpc),
    .o_imem_req_valid(req_v), .o_imem_req_addr(req_a), .i_imem_req_ready(rdy),
    .i_imem_rsp_valid(rsp), .i_imem_rsp_data(rdat),
    .o_out_valid(ov), .o_out_pc(op), .o_out_instr(oi), .i_out_ready(ordy)
  );

  // wrap DUT (RESET_PC at top of address space)
  logic        w_rst_n, w_redir, w_rdy, w_rsp, w_ordy;
  logic [31:0] w_rpc, w_rdat;
  logic        w_req_v, w_ov;
  logic [31:0] w_req_a, w_op, w_oi;

  fetch_pc #(.AW(32), .RESET_PC(32'hFFFF_FFFC), .IW(32)) dut_wrap (
    .i_clk(clk), .i_reset_n(w_rst_n),
    .i_redirect_valid(w_redir), .i_redirect_pc(w_rpc),
    .o_imem_req_valid(w_req_v), .o_imem_req_addr(w_req_a), .i_imem_req_ready(w_rdy),
    .i_imem_rsp_valid(w_rsp), .i_imem_rsp_data(w_rdat),
    .o_out_valid(w_ov), .o_out_pc(w_op), .o_out_instr(w_oi), .i_out_ready(w_ordy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rv;   logic [31:0] rpc;
    logic        rdy;  logic        rsp;  logic [31:0] rdat; logic ordy;
    logic        e_rv; logic [31:0] e_addr;
    logic        e_ov; logic [31:0] e_op; logic [31:0] e_oi;
  } vec_t;

  function automatic vec_t mk(logic rv_, logic [31:0] rpc_, logic rdy_, logic rsp_,
                              logic [31:0] rdat_, logic ordy_, logic erv, logic [31:0] ea,
                              logic eov, logic [31:0] eop, logic [31:0] eoi);
    vec_t v;
    v.rv = rv_; v.rpc = rpc_; v.rdy = rdy_; v.rsp = rsp_; v.rdat = rdat_; v.ordy = ordy_;
    v.e_rv = erv; v.e_addr = ea; v.e_ov = eov; v.e_op = eop; v.e_oi = eoi;
    return v;
  endfunction

  // memory content used by the random phase
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1111_0000;
  endfunction

  vec_t tbl [23];

  // reference model state (transaction level)
  bit          m_infl, m_kill, m_sv, exp_rv;
  logic [31:0] m_pc, m_fa, m_op, m_oi;
  // memory environment
  bit          mem_pend, genuine;
  int          mem_cnt;
  logic [31:0] mem_a;

  initial begin
    rst_n = 1'b0; redir = 1'b0; rpc = '0; rdy = 1'b0; rsp = 1'b0; rdat = '0; ordy = 1'b0;
    w_rst_n = 1'b0; w_redir = 1'b0; w_rpc = '0; w_rdy = 1'b0; w_rsp = 1'b0; w_rdat = '0; w_ordy = 1'b0;

    // --- directed table: cols = redir,rpc,rdy,rsp,rdat,ordy | rv,addr,ov,op,oi
    tbl[0]  = mk(0,32'h0,  1,0,32'h0,1,          1,32'h0,  0,32'h0,  32'h0);
    tbl[1]  = mk(0,32'h0,  0,1,32'h1111_0000,1,  0,32'h0,  0,32'h0,  32'h0);
    tbl[2]  = mk(0,32'h0,  1,0,32'h0,1,          1,32'h4,  1,32'h0,  32'h1111_0000);
    tbl[3]  = mk(0,32'h0,  0,1,32'h1111_0004,1,  0,32'h4,  0,32'h0,  32'h1111_0000);
    tbl[4]  = mk(0,32'h0,  1,0,32'h0,0,          0,32'h8,  1,32'h4,  32'h1111_0004);
    tbl[5]  = mk(0,32'h0,  1,0,32'h0,0,          0,32'h8,  1,32'h4,  32'h1111_0004);
    tbl[6]  = mk(0,32'h0,  1,0,32'h0,1,          1,32'h8,  1,32'h4,  32'h1111_0004);
    tbl[7]  = mk(1,32'h103,0,0,32'h0,1,          0,32'h8,  0,32'h4,  32'h1111_0004);
    tbl[8]  = mk(0,32'h0,  0,1,32'h1111_0008,1,  0,32'h100,0,32'h4,  32'h1111_0004);
    tbl[9]  = mk(0,32'h0,  1,0,32'h0,1,          1,32'h100,0,32'h4,  32'h1111_0004);
    tbl[10] = mk(0,32'h0,  0,1,32'h1111_0100,1,  0,32'h100,0,32'h4,  32'h1111_0004);
    tbl[11] = mk(1,32'h40, 1,0,32'h0,1,          0,32'h104,1,32'h100,32'h1111_0100);
    tbl[12] = mk(0,32'h0,  1,0,32'h0,1,          1,32'h40, 0,32'h100,32'h1111_0100);
    tbl[13] = mk(1,32'h80, 0,1,32'h1111_0040,1,  0,32'h40, 0,32'h100,32'h1111_0100);
    for (int k = 14; k <= 18; k++)
      tbl[k] = mk(0,32'h0, 0,0,32'h0,1,          1,32'h80, 0,32'h100,32'h1111_0100);
    tbl[19] = mk(0,32'h0,  1,0,32'h0,1,          1,32'h80, 0,32'h100,32'h1111_0100);
    tbl[20] = mk(0,32'h0,  0,1,32'h1111_0080,1,  0,32'h80, 0,32'h100,32'h1111_0100);
    tbl[21] = mk(0,32'h0,  0,1,32'hDEAD_BEEF,1,  1,32'h84, 1,32'h80, 32'h1111_0080);
    tbl[22] = mk(0,32'h0,  0,0,32'h0,0,          1,32'h84, 0,32'h80, 32'h1111_0080);

    // --- reset state
    #2;
    chk("rst req_valid", 32'(req_v), 32'h0);
    chk("rst out_valid", 32'(ov), 32'h0);
    chk("rst out_pc", op, 32'h0);
    chk("rst out_instr", oi, 32'h0);

    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      redir = tbl[i].rv; rpc = tbl[i].rpc; rdy = tbl[i].rdy;
      rsp = tbl[i].rsp; rdat = tbl[i].rdat; ordy = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d req_valid", i), 32'(req_v), 32'(tbl[i].e_rv));
      chk($sformatf("vec%0d req_addr", i), req_a, tbl[i].e_addr);
      chk($sformatf("vec%0d out_valid", i), 32'(ov), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d out_pc", i), op, tbl[i].e_op);
      chk($sformatf("vec%0d out_instr", i), oi, tbl[i].e_oi);
      @(posedge clk); #1;
    end

    // --- reset asserted while waiting, clock stopped
    redir = 1'b0; rsp = 1'b0; rdy = 1'b1; ordy = 1'b0;
    #1;
    chk("accept 84 valid", 32'(req_v), 32'h1);
    chk("accept 84 addr", req_a, 32'h84);
    @(posedge clk); #1;
    clk_en = 1'b0;
    rdy = 1'b0; rsp = 1'b1; rdat = 32'h1111_0084;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst req_valid", 32'(req_v), 32'h0);
    chk("async rst out_valid", 32'(ov), 32'h0);
    chk("async rst out_pc", op, 32'h0);
    chk("async rst out_instr", oi, 32'h0);
    #10;
    rsp = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post rst req_valid", 32'(req_v), 32'h1);
    chk("post rst req_addr", req_a, 32'h0);
    clk_en = 1'b1;
    rdy = 1'b1; ordy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0; rsp = 1'b1; rdat = 32'h1111_0000;
    #1;
    chk("no stale delivery", 32'(ov), 32'h0);
    @(posedge clk); #1;
    rsp = 1'b0;
    #1;
    chk("post rst out_valid", 32'(ov), 32'h1);
    chk("post rst out_pc", op, 32'h0);
    chk("post rst out_instr", oi, 32'h1111_0000);

    // --- PC wrap on the second instance
    @(posedge clk); #1;
    w_rst_n = 1'b1; w_rdy = 1'b1; w_ordy = 1'b1;
    #1;
    chk("wrap req0 valid", 32'(w_req_v), 32'h1);
    chk("wrap req0 addr", w_req_a, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    w_rsp = 1'b1; w_rdat = 32'h1110_FFFC;
    @(posedge clk); #1;
    w_rsp = 1'b0;
    #1;
    chk("wrap out0 valid", 32'(w_ov), 32'h1);
    chk("wrap out0 pc", w_op, 32'hFFFF_FFFC);
    chk("wrap out0 instr", w_oi, 32'h1110_FFFC);
    chk("wrap req1 addr", w_req_a, 32'h0);
    @(posedge clk); #1;
    w_rsp = 1'b1; w_rdat = 32'h1111_0000;
    @(posedge clk); #1;
    w_rsp = 1'b0;
    #1;
    chk("wrap out1 valid", 32'(w_ov), 32'h1);
    chk("wrap out1 pc", w_op, 32'h0);

    // --- randomized run against the reference model
    rst_n = 1'b0; redir = 1'b0; rdy = 1'b0; rsp = 1'b0; ordy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_infl = 0; m_kill = 0; m_sv = 0;
    m_pc = 32'h0; m_fa = 32'h0; m_op = 32'h0; m_oi = 32'h0;
    mem_pend = 0; mem_cnt = 0; mem_a = 32'h0;

    for (int c = 0; c < 3000; c++) begin
      redir = ($urandom_range(0, 99) < 8);
      rpc   = $urandom();
      rdy   = ($urandom_range(0, 99) < 70);
      ordy  = ($urandom_range(0, 99) < 60);
      if (mem_pend && mem_cnt == 0) begin
        rsp = 1'b1; rdat = memf(mem_a);
      end else if (!mem_pend && $urandom_range(0, 99) < 5) begin
        rsp = 1'b1; rdat = $urandom();   // stray response, must be ignored
      end else begin
        rsp = 1'b0; rdat = $urandom();
      end
      #1;

      // a fetch is offered only with nothing in flight, no redirect, and room in the slot
      exp_rv = !m_infl && !redir && (!m_sv || ordy);
      chk($sformatf("rnd%0d req_valid", c), 32'(req_v), 32'(exp_rv));
      if (exp_rv) chk($sformatf("rnd%0d req_addr", c), req_a, m_pc);
      chk($sformatf("rnd%0d out_valid", c), 32'(ov), 32'(m_sv));
      chk($sformatf("rnd%0d out_pc", c), op, m_op);
      chk($sformatf("rnd%0d out_instr", c), oi, m_oi);

      // memory environment
      genuine = rsp && mem_pend && (mem_cnt == 0);
      if (genuine) mem_pend = 0;
      else if (mem_pend) mem_cnt--;
      if (req_v && rdy) begin
        mem_pend = 1; mem_a = req_a; mem_cnt = $urandom_range(0, 2);
      end

      // reference model
      if (m_sv && ordy) m_sv = 0;
      if (rsp && m_infl) begin
        if (!m_kill && !redir) begin
          m_sv = 1; m_op = m_fa; m_oi = memf(m_fa); m_pc = m_fa + 32'd4;
        end
        m_infl = 0;
      end
      if (redir) begin
        m_pc = {rpc[31:2], 2'b00};
        m_sv = 0;
        if (m_infl) m_kill = 1;
      end
      if (exp_rv && rdy) begin
        m_infl = 1; m_kill = 0; m_fa = m_pc;
      end

      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
